// File: rtl/sistemas_sincronos_demux_pkg.sv
// Shared definitions for the synchronous selector / demux pair:
// the collect/hold state encoding and the default word width.
package sistemas_sincronos_pkg;

  // Default word width, shared with the 4:1 selector block.
  localparam int DEFAULT_WIDTH = 4;

  // Demux state: gathering bits, or holding a complete word.
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/sistemas_sincronos_demux.sv
// Serial-to-parallel collector.
// Each strobe writes one bit at a selected position. When every position
// has been written, the word is presented with a valid/ready handshake.
// Optional build macro SISTEMAS_SINCRONOS_DEMUX_ORDER_CHECK_EN adds
// o_order_err, which flags writes that arrive out of ascending position order.
module sistemas_sincronos_demux
  import sistemas_sincronos_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_d,
  input  logic [SEL_W-1:0] i_selector,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_overrun
`ifdef SISTEMAS_SINCRONOS_DEMUX_ORDER_CHECK_EN
  ,
  output logic             o_order_err
`endif
);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   buf_r;
  logic [WIDTH-1:0]   buf_nxt_s;
  logic [WIDTH-1:0]   mask_r;
  logic [WIDTH-1:0]   mask_nxt_s;
  logic [WIDTH-1:0]   data_r;
  logic               valid_r;
  logic               busy_r;
  logic               overrun_r;

  logic [WIDTH-1:0]   onehot_s;
  logic               in_range_s;
  logic [WIDTH-1:0]   wr_bits_s;
  logic [WIDTH-1:0]   word_s;
  logic [WIDTH-1:0]   mask_or_s;
  logic               capture_s;
  logic               load_s;
  logic               overrun_s;

  // Decode the selector into a one-hot write mask; out-of-range values decode to zero.
  always_comb begin
    onehot_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (i_selector == SEL_W'(i)) begin
        onehot_s[i] = 1'b1;
      end else begin
        onehot_s[i] = 1'b0;
      end
    end
    in_range_s = |onehot_s;
    wr_bits_s  = onehot_s & {WIDTH{i_d}};
    word_s     = (buf_r & ~onehot_s) | wr_bits_s;
    mask_or_s  = mask_r | onehot_s;
  end

  // Next-state, buffer/mask update and per-cycle event decode.
  always_comb begin
    state_nxt_s = state_r;
    buf_nxt_s   = buf_r;
    mask_nxt_s  = mask_r;
    capture_s   = 1'b0;
    load_s      = 1'b0;
    overrun_s   = 1'b0;
    case (state_r)
      COLLECT: begin
        if (i_valid) begin
          if (in_range_s) begin
            capture_s = 1'b1;
            if (&mask_or_s) begin
              // Last missing bit: hand the word over and start clean.
              load_s      = 1'b1;
              state_nxt_s = HOLD;
              buf_nxt_s   = {WIDTH{1'b0}};
              mask_nxt_s  = {WIDTH{1'b0}};
            end else begin
              buf_nxt_s  = word_s;
              mask_nxt_s = mask_or_s;
            end
          end else begin
            overrun_s = 1'b1;
          end
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      HOLD: begin
        if (i_ready) begin
          state_nxt_s = COLLECT;
          if (i_valid) begin
            if (in_range_s) begin
              // A write in the acceptance cycle opens the next word.
              capture_s  = 1'b1;
              buf_nxt_s  = wr_bits_s;
              mask_nxt_s = onehot_s;
            end else begin
              overrun_s = 1'b1;
            end
          end else begin
            mask_nxt_s = {WIDTH{1'b0}};
          end
        end else begin
          if (i_valid) begin
            overrun_s = 1'b1;
          end else begin
            overrun_s = 1'b0;
          end
        end
      end
      default: begin
        state_nxt_s = COLLECT;
        buf_nxt_s   = {WIDTH{1'b0}};
        mask_nxt_s  = {WIDTH{1'b0}};
      end
    endcase
  end

  // State, collect buffer and registered handshake/status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= COLLECT;
      buf_r     <= {WIDTH{1'b0}};
      mask_r    <= {WIDTH{1'b0}};
      data_r    <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      buf_r     <= buf_nxt_s;
      mask_r    <= mask_nxt_s;
      if (load_s) begin
        data_r <= word_s;
      end else begin
        data_r <= data_r;
      end
      valid_r   <= (state_nxt_s == HOLD);
      busy_r    <= (state_nxt_s == COLLECT) && (mask_nxt_s != {WIDTH{1'b0}});
      overrun_r <= overrun_s;
    end
  end

  assign o_data    = data_r;
  assign o_valid   = valid_r;
  assign o_busy    = busy_r;
  assign o_overrun = overrun_r;

`ifdef SISTEMAS_SINCRONOS_DEMUX_ORDER_CHECK_EN
  logic [SEL_W-1:0] exp_pos_r;
  logic             order_err_r;

  // Expected-position counter and order-error pulse for accepted writes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exp_pos_r   <= {SEL_W{1'b0}};
      order_err_r <= 1'b0;
    end else begin
      order_err_r <= capture_s && (i_selector != exp_pos_r);
      if (load_s) begin
        exp_pos_r <= {SEL_W{1'b0}};
      end else if (capture_s) begin
        if (exp_pos_r == SEL_W'(WIDTH - 1)) begin
          exp_pos_r <= {SEL_W{1'b0}};
        end else begin
          exp_pos_r <= exp_pos_r + SEL_W'(1);
        end
      end else begin
        exp_pos_r <= exp_pos_r;
      end
    end
  end

  assign o_order_err = order_err_r;
`endif

endmodule

// File: tb/tb_sistemas_sincronos_demux.sv
// Self-checking bench for sistemas_sincronos_demux (WIDTH=4).
// Completed words are pushed to a scoreboard queue when their final strobe
// is driven and popped when o_valid is observed.
module tb_sistemas_sincronos_demux;

  localparam int WIDTH = 4;
  localparam int SEL_W = 2;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_d = 1'b0;
  logic [SEL_W-1:0] i_selector = '0;
  logic             i_valid = 1'b0;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic             o_busy;
  logic             o_overrun;
`ifdef SISTEMAS_SINCRONOS_DEMUX_ORDER_CHECK_EN
  logic             o_order_err;
`endif

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_w;

  sistemas_sincronos_demux #(.WIDTH(WIDTH)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_d        (i_d),
    .i_selector (i_selector),
    .i_valid    (i_valid),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_busy     (o_busy),
    .o_overrun  (o_overrun)
`ifdef SISTEMAS_SINCRONOS_DEMUX_ORDER_CHECK_EN
    ,
    .o_order_err(o_order_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Drive one write strobe for one clock; returns 1 time unit after the edge.
  task automatic strobe(input int sel, input logic d);
    i_selector = SEL_W'(sel);
    i_d = d;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #2;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_overrun !== 1'b0 || o_data !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state got v=%b b=%b o=%b d=%b expected 0 0 0 0000", o_valid, o_busy, o_overrun, o_data);
    end
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_in_order();
    i_ready = 1'b0;
    strobe(0, 1'b1);
    checks++;
    if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL in_order_busy got b=%b v=%b expected 1 0", o_busy, o_valid);
    end
    strobe(1, 1'b0);
    strobe(2, 1'b0);
    exp_q.push_back(4'b1001);
    strobe(3, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL in_order_valid got v=%b b=%b expected 1 0", o_valid, o_busy);
    end
    exp_w = exp_q.pop_front();
    checks++;
    if (o_data !== exp_w) begin
      failures++;
      $display("FAIL in_order_data got %b expected %b", o_data, exp_w);
    end
  endtask

  task automatic test_hold_accept();
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 4'b1001) begin
        failures++;
        $display("FAIL hold_stable cycle %0d got v=%b d=%b expected 1 1001", i, o_valid, o_data);
      end
    end
    i_ready = 1'b1;
    idle_cycle();
    i_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL accept_drop got v=%b b=%b expected 0 0", o_valid, o_busy);
    end
    i_ready = 1'b1;
    idle_cycle();
    i_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 4'b1001) begin
      failures++;
      $display("FAIL ready_idle got v=%b d=%b expected 0 1001", o_valid, o_data);
    end
  endtask

  task automatic test_overrun();
    strobe(0, 1'b0);
    strobe(1, 1'b1);
    strobe(2, 1'b1);
    exp_q.push_back(4'b0110);
    strobe(3, 1'b0);
    exp_w = exp_q.pop_front();
    checks++;
    if (o_valid !== 1'b1 || o_data !== exp_w) begin
      failures++;
      $display("FAIL overrun_word got v=%b d=%b expected 1 %b", o_valid, o_data, exp_w);
    end
    strobe(0, 1'b1);
    checks++;
    if (o_overrun !== 1'b1 || o_data !== 4'b0110 || o_valid !== 1'b1) begin
      failures++;
      $display("FAIL overrun_pulse got o=%b d=%b v=%b expected 1 0110 1", o_overrun, o_data, o_valid);
    end
    idle_cycle();
    checks++;
    if (o_overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_width got %b expected 0", o_overrun);
    end
    i_ready = 1'b1;
    strobe(0, 1'b1);
    i_ready = 1'b0;
    checks++;
    if (o_overrun !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL accept_write got o=%b v=%b b=%b expected 0 0 1", o_overrun, o_valid, o_busy);
    end
    strobe(1, 1'b0);
    strobe(2, 1'b1);
    exp_q.push_back(4'b0101);
    strobe(3, 1'b0);
    exp_w = exp_q.pop_front();
    checks++;
    if (o_valid !== 1'b1 || o_data !== exp_w) begin
      failures++;
      $display("FAIL carry_word got v=%b d=%b expected 1 %b", o_valid, o_data, exp_w);
    end
    i_ready = 1'b1;
    idle_cycle();
    i_ready = 1'b0;
  endtask

  task automatic test_out_of_order();
    strobe(2, 1'b1);
    strobe(2, 1'b0);
    strobe(0, 1'b1);
    strobe(3, 1'b0);
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL rewrite_not_done got v=%b b=%b expected 0 1", o_valid, o_busy);
    end
    exp_q.push_back(4'b0011);
    strobe(1, 1'b1);
    exp_w = exp_q.pop_front();
    checks++;
    if (o_valid !== 1'b1 || o_data !== exp_w) begin
      failures++;
      $display("FAIL ooo_word got v=%b d=%b expected 1 %b", o_valid, o_data, exp_w);
    end
    i_ready = 1'b1;
    idle_cycle();
    i_ready = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    strobe(0, 1'b1);
    strobe(1, 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_data !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid got b=%b v=%b d=%b expected 0 0 0000", o_busy, o_valid, o_data);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle_cycle();
    strobe(0, 1'b1);
    strobe(1, 1'b1);
    strobe(2, 1'b1);
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_stale got v=%b expected 0", o_valid);
    end
    exp_q.push_back(4'b1111);
    strobe(3, 1'b1);
    exp_w = exp_q.pop_front();
    checks++;
    if (o_valid !== 1'b1 || o_data !== exp_w) begin
      failures++;
      $display("FAIL post_reset_word got v=%b d=%b expected 1 %b", o_valid, o_data, exp_w);
    end
    i_ready = 1'b1;
    idle_cycle();
    i_ready = 1'b0;
  endtask

`ifdef SISTEMAS_SINCRONOS_DEMUX_ORDER_CHECK_EN
  task automatic test_order_check();
    int sels[4] = '{0, 2, 1, 3};
    logic ds[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic errs[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp_q.push_back(4'b1011);
    for (int i = 0; i < 4; i++) begin
      strobe(sels[i], ds[i]);
      checks++;
      if (o_order_err !== errs[i]) begin
        failures++;
        $display("FAIL order_err step %0d got %b expected %b", i, o_order_err, errs[i]);
      end
    end
    exp_w = exp_q.pop_front();
    checks++;
    if (o_valid !== 1'b1 || o_data !== exp_w) begin
      failures++;
      $display("FAIL order_word got v=%b d=%b expected 1 %b", o_valid, o_data, exp_w);
    end
    i_ready = 1'b1;
    idle_cycle();
    i_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_in_order();
    test_hold_accept();
    test_overrun();
    test_out_of_order();
    test_reset_mid_word();
`ifdef SISTEMAS_SINCRONOS_DEMUX_ORDER_CHECK_EN
    test_order_check();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sistemas_sincronos_demux.md
Name: sistemas_sincronos_demux

Overview:
- Receive-side counterpart of the synchronous 4:1 selector.
- Takes one serial bit per strobe, tagged with a bit-position selector, and writes it into a collect buffer.
- Once every position has been written, presents the assembled parallel word with a valid/ready handshake.
- Sits downstream of the selector path and rebuilds i_data from a sequence of (o_q, i_selector) samples.

Parameters:
- WIDTH, 4: word width and number of bit positions; must be at least 2.
- SEL_W, $clog2(WIDTH): selector width; derived, not overridden.

Ports:
- i_clk  input  1  clock; every register updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_d  input  1  serial data bit.
- i_selector  input  SEL_W  target bit position of i_d.
- i_valid  input  1  write strobe; i_d and i_selector are sampled when it is high.
- o_data  output  WIDTH  assembled word; stable while o_valid is high.
- o_valid  output  1  word available.
- i_ready  input  1  consumer accepts the word when o_valid and i_ready are both high.
- o_busy  output  1  at least one position has been written and the word is not complete.
- o_overrun  output  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - state=COLLECT; buffer, mask and o_data cleared to 0.
  - o_valid=0, o_busy=0, o_overrun=0.
  - Any word in progress or held word is discarded.
- Internal registers: r_buf[WIDTH], r_mask[WIDTH] (one bit per written position), and the state.
- COLLECT state:
  - On i_valid, r_buf[i_selector]<=i_d and r_mask[i_selector]<=1.
  - Rewriting an already-written position overwrites the bit; the mask is unchanged.
  - Selector values >= WIDTH (only possible when WIDTH is not a power of 2) are dropped and pulse o_overrun.
  - When the write sets the last clear mask bit: next cycle o_data<={buffer incl. that bit}, o_valid=1, state=HOLD, r_mask cleared. Latency from completing strobe to o_valid is 1 cycle.
  - o_busy = (r_mask != 0) while in COLLECT.
- HOLD state:
  - o_valid=1; o_data frozen.
  - i_valid without acceptance: write dropped, o_overrun pulses 1 cycle (next cycle).
  - Acceptance cycle (i_ready=1): next cycle o_valid=0, state=COLLECT.
  - A write arriving in the acceptance cycle is captured as the first bit of the next word: r_mask has only that bit set, and r_buf holds only that bit, all others cleared. No overrun is reported.
  - i_ready while o_valid=0 has no effect.
- Word boundaries are defined solely by mask completion; write order is free (see Optional Feature).
- A reset asserted mid-word or in HOLD clears everything immediately. The first edge after release behaves as in COLLECT with an empty mask.

Optional Feature:
- Macro: SISTEMAS_SINCRONOS_DEMUX_ORDER_CHECK_EN.
- Enabled:
  - Adds output port o_order_err (1 bit) and an internal expected-position counter, reset to 0.
  - Each accepted write compares i_selector against the counter. On mismatch, o_order_err pulses 1 cycle and the bit is still written.
  - The counter increments on each accepted write and wraps to 0 when the word completes or on reset.
- Disabled: no port, no counter, no order checking.

Decomposition:
- Package sistemas_sincronos_pkg holds:
  - the state typedef (COLLECT, HOLD);
  - the default WIDTH constant, shared with the selector block.
- No sub-module. State machine, buffer/mask and handshake fit in one module.

Test Plan:
- In-order word: after reset, write (sel,d) = (0,1),(1,0),(2,0),(3,1) on consecutive cycles, i_ready=0 -> one cycle after 4th strobe o_valid=1, o_data=4'b1001, o_busy=0.
- Hold and accept: keep i_ready=0 for 5 cycles then 1 for one cycle -> o_data stays 4'b1001 throughout; o_valid falls the cycle after acceptance.
- Overrun: in HOLD, strobe (0,1) with i_ready=0 -> o_overrun=1 for exactly one cycle; o_data unchanged. Same strobe in the acceptance cycle -> no overrun, and the next word starts with bit0=1.
- Rewrite and out-of-order: writes (2,1),(2,0),(0,1),(3,0),(1,1) -> o_valid after the 5th strobe, o_data=4'b0011.
- Reset mid-word: write (0,1),(1,1), assert i_rst_n=0 between clock edges -> o_busy=0, o_valid=0 and o_data=0 immediately. Then a full word 1,1,1,1 -> o_data=4'b1111.
- Order check (macro defined): writes sel 0,2,1,3 -> o_order_err pulses after sel 2 and after sel 1; o_data is still assembled correctly.
